// File: rtl/seg_pkg.sv
// Shared definitions for the iterative-threshold segmenter: output modes,
// update FSM states and accumulator width helpers.
package seg_pkg;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_ZERO = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV_LO = 2'd1,
        ST_DIV_HI = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Width of a pixel sum over a whole frame; cannot overflow.
    function automatic int sum_w(input int dw, input int npix);
        return dw + $clog2(npix);
    endfunction

    // Width of a pixel count that can hold the full frame size.
    function automatic int cnt_w(input int npix);
        return $clog2(npix + 1);
    endfunction

endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per clock. The quotient
// register doubles as the dividend shifter.
module seq_div #(
    parameter int NW  = 11,
    parameter int DWD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NW-1:0]  dividend,
    input  logic [DWD-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [NW-1:0]  quotient
);
    localparam int CW = $clog2(NW + 1);

    logic [DWD-1:0] rem;
    logic [DWD-1:0] dsr;
    logic [CW-1:0]  cnt;
    logic [DWD:0]   shifted;
    logic [DWD:0]   diff;
    logic           ge;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {rem, quotient[NW-1]};
        diff    = shifted - {1'b0, dsr};
        ge      = (shifted >= {1'b0, dsr});
    end

    // Iteration control; done pulses on the cycle the last bit lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy     <= 1'b1;
                rem      <= '0;
                dsr      <= divisor;
                quotient <= dividend;
                cnt      <= CW'(NW);
            end else if (busy) begin
                rem      <= ge ? diff[DWD-1:0] : shifted[DWD-1:0];
                quotient <= {quotient[NW-2:0], ge};
                cnt      <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iter_thresh_segment.sv
// Video threshold segmenter. Each frame is split at the applied threshold;
// the mean of each side is computed during blanking and their midpoint
// becomes the threshold for the next frame.
module iter_thresh_segment
    import seg_pkg::*;
#(
    parameter int DW     = 8,
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int T_INIT = 2**(DW-1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Y_hsync,
    input  logic          Y_vsync,
    input  logic          Y_de,
    input  logic [DW-1:0] Y_data,
    input  logic [1:0]    mode,
    output logic          segment_hsync,
    output logic          segment_vsync,
    output logic          segment_de,
    output logic [DW-1:0] segment_data,
    output logic [DW-1:0] threshold,
    output logic          thresh_upd,
    output logic          stat_drop
);
    localparam int NPIX  = H_DISP * V_DISP;
    localparam int SUM_W = sum_w(DW, NPIX);
    localparam int CNT_W = cnt_w(NPIX);
    localparam logic [DW-1:0] T_RST = DW'(T_INIT);

    logic             vs_q, seen, frame_end, frame_start, over;
    logic [SUM_W-1:0] under_sum, over_sum, snap_us, snap_os, div_num, div_q;
    logic [CNT_W-1:0] under_cnt, over_cnt, snap_uc, snap_oc, div_den;
    logic [DW-1:0]    m1, m2, pend, q_sat;
    logic [DW:0]      t_sum;
    logic             launched, div_start, div_busy, div_done;
    state_t           state;

    // Frame edges, pixel classification, divider operand selection.
    always_comb begin
        frame_end   = vs_q & ~Y_vsync;
        frame_start = ~vs_q & Y_vsync;
        over        = (Y_data > threshold);
        div_num     = (state == ST_DIV_HI) ? snap_os : snap_us;
        div_den     = (state == ST_DIV_HI) ? snap_oc : snap_uc;
        div_start   = ((state == ST_DIV_LO) || (state == ST_DIV_HI)) && !launched
                      && !div_busy && (div_den != '0);
        q_sat       = ((div_q >> DW) != '0) ? '1 : div_q[DW-1:0];
        t_sum       = ({1'b0, m1} + {1'b0, m2}) >> 1;
    end

    // One-clock output stage: syncs delayed, pixel mapped by mode.
    // vs_q resets high so a frame already in progress at reset release is
    // never mistaken for a fresh frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segment_hsync <= 1'b0;
            segment_vsync <= 1'b0;
            segment_de    <= 1'b0;
            segment_data  <= '0;
            vs_q          <= 1'b1;
        end else begin
            segment_hsync <= Y_hsync;
            segment_vsync <= Y_vsync;
            segment_de    <= Y_de;
            vs_q          <= Y_vsync;
            if (!Y_de)
                segment_data <= '0;
            else begin
                case (mode)
                    MODE_INV:  segment_data <= over ? '0 : '1;
                    MODE_ZERO: segment_data <= over ? Y_data : '0;
                    default:   segment_data <= over ? '1 : '0;
                endcase
            end
        end
    end

    // Per-frame statistics; threshold only changes at a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            under_sum <= '0;
            over_sum  <= '0;
            under_cnt <= '0;
            over_cnt  <= '0;
            threshold <= T_RST;
            seen      <= 1'b0;
        end else begin
            if (frame_start) begin
                threshold <= pend;
                seen      <= 1'b1;
            end
            if (frame_end) begin
                under_sum <= '0;
                over_sum  <= '0;
                under_cnt <= '0;
                over_cnt  <= '0;
            end else if (Y_de) begin
                if (over) begin
                    over_sum <= over_sum + SUM_W'(Y_data);
                    over_cnt <= over_cnt + CNT_W'(1);
                end else begin
                    under_sum <= under_sum + SUM_W'(Y_data);
                    under_cnt <= under_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Update FSM: snapshot at frame end, two divisions, midpoint.
    // A frame only counts once a frame start has been seen after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            launched   <= 1'b0;
            m1         <= '0;
            m2         <= '0;
            pend       <= T_RST;
            thresh_upd <= 1'b0;
            stat_drop  <= 1'b0;
            snap_us    <= '0;
            snap_os    <= '0;
            snap_uc    <= '0;
            snap_oc    <= '0;
        end else begin
            thresh_upd <= 1'b0;
            if (frame_end && seen && (state != ST_IDLE))
                stat_drop <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (frame_end && seen) begin
                        snap_us <= under_sum;
                        snap_os <= over_sum;
                        snap_uc <= under_cnt;
                        snap_oc <= over_cnt;
                        state   <= ST_DIV_LO;
                    end
                end
                ST_DIV_LO: begin
                    if (!launched) begin
                        if (snap_uc == '0) begin
                            m1    <= threshold;
                            state <= ST_DIV_HI;
                        end else
                            launched <= 1'b1;
                    end else if (div_done) begin
                        m1       <= q_sat;
                        launched <= 1'b0;
                        state    <= ST_DIV_HI;
                    end
                end
                ST_DIV_HI: begin
                    if (!launched) begin
                        if (snap_oc == '0) begin
                            m2    <= threshold;
                            state <= ST_UPDATE;
                        end else
                            launched <= 1'b1;
                    end else if (div_done) begin
                        m2       <= q_sat;
                        launched <= 1'b0;
                        state    <= ST_UPDATE;
                    end
                end
                default: begin
                    pend       <= t_sum[DW-1:0];
                    thresh_upd <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    seq_div #(.NW(SUM_W), .DWD(CNT_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

endmodule

// File: doc/iter_thresh_segment.md
ITER_THRESH_SEGMENT -- requirements
Module: iter_thresh_segment

Interface
REQ-001 Parameter DW, default 8: pixel data width.
REQ-002 Parameter H_DISP, default 640: active pixels per line.
REQ-003 Parameter V_DISP, default 480: active lines per frame.
REQ-004 Parameter T_INIT, default 2**(DW-1): threshold loaded at reset.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 Y_hsync, Y_vsync, Y_de  in  1 each: input line sync, frame sync (high = frame active), data enable.
REQ-008 Y_data  in  DW  input luma pixel.
REQ-009 mode  in  2  output mode: 0 binary, 1 inverted binary, 2 to-zero, 3 reserved (behaves as 0).
REQ-010 segment_hsync, segment_vsync, segment_de  out  1 each: input syncs delayed 1 clk.
REQ-011 segment_data  out  DW  segmented pixel.
REQ-012 threshold  out  DW  threshold applied to the current frame.
REQ-013 thresh_upd  out  1  one-clk pulse when a new threshold is computed.
REQ-014 stat_drop  out  1  sticky flag: a frame's statistics were discarded.

Function
REQ-015 Frame end = Y_vsync falling edge; frame start = Y_vsync rising edge (edges detected on 1-clk registered vsync).
REQ-016 During Y_de, pixel > applied threshold T adds to over_sum/over_cnt, else to under_sum/under_cnt; SUM_W = DW + clog2(H_DISP*V_DISP), CNT_W = clog2(H_DISP*V_DISP+1), no overflow possible.
REQ-017 At frame end with FSM in IDLE: sums/counts copied to snapshot registers, accumulators cleared same clk, FSM -> DIV_LO.
REQ-018 FSM states IDLE, DIV_LO, DIV_HI, UPDATE; DIV_LO: m1 = under_sum/under_cnt; DIV_HI: m2 = over_sum/over_cnt; each via shared sequential divider, advance on divider done.
REQ-019 Zero count: divider not started, mean forced to current T, state advances next clk.
REQ-020 UPDATE: T_next = (m1 + m2) >> 1 computed at DW+1 bits, stored in pending register, thresh_upd pulses 1 clk, FSM -> IDLE.
REQ-021 threshold output loads pending T only at frame start; a frame always uses one T throughout.
REQ-022 Frame end while FSM not IDLE: accumulators cleared, statistics discarded, stat_drop set; ongoing computation continues unaffected.
REQ-023 Accumulation continues during DIV_*/UPDATE; snapshot registers isolate divider operands.
REQ-024 Latency 1 clk: segment_data/syncs registered from the same-cycle inputs.
REQ-025 Mode 0: Y_data > T -> all-ones else 0; mode 1: complement of mode 0; mode 2: Y_data > T -> Y_data else 0.
REQ-026 segment_data = 0 when Y_de low.
REQ-027 Divider: unsigned restoring, SUM_W iterations, 1 bit/clk, quotient truncated to DW bits (saturate to all-ones if upper bits set).
REQ-028 Total update time <= 2*(SUM_W+2)+3 clk; must fit vertical blanking, otherwise REQ-021 applies update one frame later.

Reset
REQ-029 rst high: all outputs 0 except threshold = T_INIT; pending T = T_INIT; accumulators, snapshots, stat_drop cleared; FSM -> IDLE; divider aborted.
REQ-030 Reset mid-division: no thresh_upd pulse after release; first update occurs only after a complete frame post-reset.

Structure
REQ-031 Shared package seg_pkg: mode encodings, FSM state enum, width helper functions (SUM_W, CNT_W).
REQ-032 One sub-module seq_div (start/busy/done, parametrised width) instantiated once, time-shared for m1 and m2.

Verification (bench: DW=8, H_DISP=4, V_DISP=2)
REQ-033 Reset, frame of 8 pixels = 200 -> m1=128 (empty), m2=200, thresh_upd once, threshold = 164 from next frame start.
REQ-034 T=128, frame 4x50 + 4x250 -> T=150; in following frame mode 0 pixel 150 -> 0x00, 151 -> 0xFF.
REQ-035 Mode 1 and mode 2 with pixels {10,200}, T=128 -> mode 1 {0xFF,0x00}; mode 2 {0,200}; all 1 clk after input.
REQ-036 Assert rst during DIV_HI -> threshold = 128, segment outputs 0, no thresh_upd; next full frame updates normally.
REQ-037 Two frame ends 5 clk apart -> second frame discarded, stat_drop = 1, first result still delivered.
REQ-038 Pixel exactly = T counted as under; all pixels = 128 with T=128 -> m2 forced 128, T stays 128.
